// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control slice.
// Contents:
//   opcode constants, state encodings, ALUOp codes, PCSrc codes,
//   the control vector struct (ctrl_t), an opcode classification enum,
//   and the per-opcode attribute helpers used by the decoder and the next-state logic.
package multicycle_ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // State encodings
    localparam logic [2:0] S_IF   = 3'b000;
    localparam logic [2:0] S_ID   = 3'b001;
    localparam logic [2:0] S_EXE  = 3'b010;
    localparam logic [2:0] S_MEM  = 3'b011;
    localparam logic [2:0] S_WB   = 3'b100;
    localparam logic [2:0] S_HALT = 3'b111;

    // ALUOp codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;

    // PCSrc codes
    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JUMP = 2'b10;

    typedef struct packed {
        logic       pcwre;
        logic       irwre;
        logic       insmemrw;
        logic       alusrca;
        logic       alusrcb;
        logic [2:0] aluop;
        logic       extsel;
        logic       regdst;
        logic       regwre;
        logic       dbdatasrc;
        logic       mrd;
        logic       mwr;
        logic [1:0] pcsrc;
    } ctrl_t;

    // Instruction classes that decide the state path.
    typedef enum logic [2:0] {
        K_NOP, K_J, K_HALT, K_BEQ, K_SW, K_LW, K_ALU
    } opkind_t;

    function automatic opkind_t op_kind(input logic [5:0] op);
        opkind_t k;
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR,
            OP_AND, OP_ORI, OP_SLL, OP_SLT: k = K_ALU;
            OP_SW:   k = K_SW;
            OP_LW:   k = K_LW;
            OP_BEQ:  k = K_BEQ;
            OP_J:    k = K_J;
            OP_HALT: k = K_HALT;
            default: k = K_NOP;   // undefined opcodes retire as a nop
        endcase
        return k;
    endfunction

    function automatic logic [2:0] alu_op(input logic [5:0] op);
        logic [2:0] a;
        case (op)
            OP_SUB, OP_BEQ: a = ALU_SUB;
            OP_SLT:         a = ALU_SLT;
            OP_SLL:         a = ALU_SLL;
            OP_OR, OP_ORI:  a = ALU_OR;
            OP_AND:         a = ALU_AND;
            default:        a = ALU_ADD;  // add/addi/sw/lw and don't-care ops
        endcase
        return a;
    endfunction

    function automatic logic uses_imm(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ORI) || (op == OP_SW) || (op == OP_LW);
    endfunction

    function automatic logic sign_ext(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SW) || (op == OP_LW) || (op == OP_BEQ);
    endfunction

    function automatic logic is_rtype(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
               (op == OP_AND) || (op == OP_SLL) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: purely combinational control vector generation.
// Ports:
//   st   in  STW  current FSM state
//   op   in  OPW  opcode from the instruction register
//   zero in  1    ALU zero flag, only looked at in EXE for beq
//   c    out      control vector (ctrl_t)
module ctrl_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 3
) (
    input  logic [STW-1:0] st,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    output ctrl_t          c
);

    opkind_t kind;

    always_comb begin
        c    = '0;
        kind = op_kind(op);
        case (st)
            S_IF: begin
                c.insmemrw = 1'b1;
                c.irwre    = 1'b1;
            end
            S_ID, S_EXE, S_MEM, S_WB: begin
                // Datapath selects are held steady for the whole instruction.
                c.aluop   = alu_op(op);
                c.alusrca = (op == OP_SLL);
                c.alusrcb = uses_imm(op);
                c.extsel  = sign_ext(op);
                c.regdst  = is_rtype(op);
                case (st)
                    S_ID: begin
                        // j and undefined ops retire here; halt parks without a PC update.
                        if (kind == K_J) begin
                            c.pcwre = 1'b1;
                            c.pcsrc = PC_JUMP;
                        end else if (kind == K_NOP) begin
                            c.pcwre = 1'b1;
                        end
                    end
                    S_EXE: begin
                        if (kind == K_BEQ) begin
                            c.pcwre = 1'b1;
                            c.pcsrc = zero ? PC_BR : PC_SEQ;
                        end
                    end
                    S_MEM: begin
                        if (kind == K_SW) begin
                            c.pcwre = 1'b1;
                            c.mwr   = 1'b1;
                        end else if (kind == K_LW) begin
                            c.mrd   = 1'b1;
                        end
                    end
                    S_WB: begin
                        c.regwre    = 1'b1;
                        c.pcwre     = 1'b1;
                        c.dbdatasrc = (kind == K_LW);
                    end
                    default: ;
                endcase
            end
            default: ;  // HALT and unused encodings: everything off
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB/HALT).
// Holds the state register and next-state logic; control outputs come
// from ctrl_decode and are forced low while RST is high.
// Ports:
//   CLK, RST (sync, active high), op (opcode), Zero (ALU flag)
//   PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp[2:0], ExtSel, RegDst,
//   RegWre, DBDataSrc, mRD, mWR, PCSrc[1:0], state[2:0] (debug)
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 3
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] op,
    input  logic           Zero,
    output logic           PCWre,
    output logic           IRWre,
    output logic           InsMemRW,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic [2:0]     ALUOp,
    output logic           ExtSel,
    output logic           RegDst,
    output logic           RegWre,
    output logic           DBDataSrc,
    output logic           mRD,
    output logic           mWR,
    output logic [1:0]     PCSrc,
    output logic [STW-1:0] state
);

    logic [STW-1:0] st, nxt;
    opkind_t        kind;
    ctrl_t          c, co;

    always_comb begin
        nxt  = S_IF;
        kind = op_kind(op);
        case (st)
            S_IF:  nxt = S_ID;
            S_ID: begin
                case (kind)
                    K_J, K_NOP: nxt = S_IF;
                    K_HALT:     nxt = S_HALT;
                    default:    nxt = S_EXE;
                endcase
            end
            S_EXE: begin
                case (kind)
                    K_BEQ:      nxt = S_IF;
                    K_SW, K_LW: nxt = S_MEM;
                    default:    nxt = S_WB;
                endcase
            end
            S_MEM:  nxt = (kind == K_LW) ? S_WB : S_IF;
            S_WB:   nxt = S_IF;
            S_HALT: nxt = S_HALT;
            default: nxt = S_IF;   // recover from unused encodings
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) st <= S_IF;
        else     st <= nxt;
    end

    ctrl_decode #(.OPW(OPW), .STW(STW)) u_dec (
        .st   (st),
        .op   (op),
        .zero (Zero),
        .c    (c)
    );

    // Reset aborts the instruction in flight: no enable may leak out during it.
    assign co = RST ? '0 : c;

    assign PCWre     = co.pcwre;
    assign IRWre     = co.irwre;
    assign InsMemRW  = co.insmemrw;
    assign ALUSrcA   = co.alusrca;
    assign ALUSrcB   = co.alusrcb;
    assign ALUOp     = co.aluop;
    assign ExtSel    = co.extsel;
    assign RegDst    = co.regdst;
    assign RegWre    = co.regwre;
    assign DBDataSrc = co.dbdatasrc;
    assign mRD       = co.mrd;
    assign mWR       = co.mwr;
    assign PCSrc     = co.pcsrc;
    assign state     = st;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed vector table, hand-written
// halt/reset sequences, then randomized instruction streams checked
// against an instruction-path reference model.
module tb_multicycle_ctrl;

    localparam logic [5:0] ADD  = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010;
    localparam logic [5:0] OR_  = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010;
    localparam logic [5:0] SLL  = 6'b011000, SLT = 6'b100110, SW = 6'b110000;
    localparam logic [5:0] LW   = 6'b110001, BEQ = 6'b110100, J = 6'b111000;
    localparam logic [5:0] HALT = 6'b111111, UND = 6'b101010;

    logic       CLK = 1'b0;
    logic       RST, Zero;
    logic [5:0] op;
    logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, RegDst;
    logic       RegWre, DBDataSrc, mRD, mWR;
    logic [2:0] ALUOp, state;
    logic [1:0] PCSrc;

    int errs = 0;
    int checks = 0;
    int ph = 0;     // model: position within the current instruction's state path

    multicycle_ctrl #(.OPW(6), .STW(3)) dut (
        .CLK(CLK), .RST(RST), .op(op), .Zero(Zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ExtSel(ExtSel), .RegDst(RegDst), .RegWre(RegWre),
        .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR),
        .PCSrc(PCSrc), .state(state)
    );

    always #5 CLK = ~CLK;

    logic [18:0] dv;
    assign dv = {PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp, ExtSel, RegDst,
                 RegWre, DBDataSrc, mRD, mWR, PCSrc, state};

    // ---------------- reference model ----------------
    typedef logic [2:0] stq_t[$];

    function automatic logic is_alu(input logic [5:0] o);
        return o inside {ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT};
    endfunction

    // Sequence of states each instruction walks through.
    function automatic stq_t path_of(input logic [5:0] o);
        stq_t q;
        q.push_back(3'd0);
        q.push_back(3'd1);
        if (o == HALT) q.push_back(3'd7);
        else if (o == BEQ) q.push_back(3'd2);
        else if (o == SW) begin q.push_back(3'd2); q.push_back(3'd3); end
        else if (o == LW) begin q.push_back(3'd2); q.push_back(3'd3); q.push_back(3'd4); end
        else if (is_alu(o)) begin q.push_back(3'd2); q.push_back(3'd4); end
        return q;
    endfunction

    function automatic logic [18:0] expect_vec(input logic r, input logic [5:0] o,
                                               input logic z, input int p);
        stq_t q;
        logic [2:0] st, aop;
        logic last, pcw, irw, imr, sa, sb, ext, rd, rw, dbd, mr, mw;
        logic [1:0] pcs;
        q   = path_of(o);
        st  = q[p];
        last = (p == q.size() - 1) && (st != 3'd7);
        {pcw, irw, imr, sa, sb, aop, ext, rd, rw, dbd, mr, mw, pcs} = '0;
        if (!r) begin
            if (st == 3'd0) begin
                imr = 1'b1;
                irw = 1'b1;
            end else if (st != 3'd7) begin
                aop = (o == SUB || o == BEQ) ? 3'b001 :
                      (o == SLT)             ? 3'b010 :
                      (o == SLL)             ? 3'b100 :
                      (o == OR_ || o == ORI) ? 3'b101 :
                      (o == AND_)            ? 3'b110 : 3'b000;
                sa  = (o == SLL);
                sb  = o inside {ADDI, ORI, SW, LW};
                ext = o inside {ADDI, SW, LW, BEQ};
                rd  = o inside {ADD, SUB, OR_, AND_, SLL, SLT};
                pcw = last;
                pcs = (o == J && st == 3'd1) ? 2'b10 :
                      (o == BEQ && st == 3'd2 && z) ? 2'b01 : 2'b00;
                rw  = (st == 3'd4);
                dbd = (o == LW && st == 3'd4);
                mr  = (o == LW && st == 3'd3);
                mw  = (o == SW && st == 3'd3);
            end
        end
        return {pcw, irw, imr, sa, sb, aop, ext, rd, rw, dbd, mr, mw, pcs, st};
    endfunction

    task automatic step(input logic r, input logic [5:0] o, input logic z, input string nm);
        logic [18:0] ex;
        stq_t q;
        @(negedge CLK);
        RST = r; op = o; Zero = z;
        #1;
        ex = expect_vec(r, o, z, ph);
        checks++;
        if (dv !== ex) begin
            errs++;
            $display("FAIL %s: got %h want %h (op=%b ph=%0d rst=%b)", nm, dv, ex, o, ph, r);
        end
        checks++;
        if (RegWre && mWR) begin
            errs++;
            $display("FAIL %s_regwre_mwr: got both 1 want not both", nm);
        end
        @(posedge CLK);
        if (r) ph = 0;
        else begin
            q = path_of(o);
            if (q[ph] != 3'd7) ph = (ph == q.size() - 1) ? 0 : ph + 1;
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       zero;
        logic [2:0] st;
        logic       pcwre, irwre, regwre, mrd, mwr, regdst, dbd;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [5:0] o, input logic z,
                                input logic [2:0] st, input logic pw, input logic iw,
                                input logic rw, input logic mr, input logic mw,
                                input logic rd, input logic dbd, input logic [2:0] a,
                                input logic [1:0] ps);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.st = st; v.pcwre = pw; v.irwre = iw;
        v.regwre = rw; v.mrd = mr; v.mwr = mw; v.regdst = rd; v.dbd = dbd;
        v.aluop = a; v.pcsrc = ps;
        return v;
    endfunction

    initial begin
        logic [14:0] got, want;
        logic [5:0]  cur;

        //           rst op   z  st  pw iw rw mr mw rd db aluop   pcsrc
        tbl.push_back(mk(0, ADD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, ADD, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, ADD, 0, 2, 0, 0, 0, 0, 0, 1, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, ADD, 0, 4, 1, 0, 1, 0, 0, 1, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, LW,  0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, LW,  0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, LW,  0, 2, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, LW,  0, 3, 0, 0, 0, 1, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, LW,  0, 4, 1, 0, 1, 0, 0, 0, 1, 3'b000, 2'b00));
        tbl.push_back(mk(0, BEQ, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, BEQ, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00));
        tbl.push_back(mk(0, BEQ, 1, 2, 1, 0, 0, 0, 0, 0, 0, 3'b001, 2'b01));
        tbl.push_back(mk(0, BEQ, 1, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, BEQ, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00));
        tbl.push_back(mk(0, BEQ, 0, 2, 1, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00));
        tbl.push_back(mk(0, J,   0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, J,   0, 1, 1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b10));
        tbl.push_back(mk(0, UND, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, UND, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, SW,  0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, SW,  0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, SW,  0, 2, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, SW,  0, 3, 1, 0, 0, 0, 1, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, SLT, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, SLT, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3'b010, 2'b00));
        tbl.push_back(mk(0, SLT, 0, 2, 0, 0, 0, 0, 0, 1, 0, 3'b010, 2'b00));
        tbl.push_back(mk(0, SLT, 0, 4, 1, 0, 1, 0, 0, 1, 0, 3'b010, 2'b00));
        // reset in the middle of add's EXE: everything off, then a clean fetch
        tbl.push_back(mk(0, ADD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, ADD, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3'b000, 2'b00));
        tbl.push_back(mk(1, ADD, 0, 2, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00));

        RST = 1'b1; op = ADD; Zero = 1'b0;
        repeat (2) @(posedge CLK);

        foreach (tbl[i]) begin
            @(negedge CLK);
            RST = tbl[i].rst; op = tbl[i].op; Zero = tbl[i].zero;
            #1;
            got  = {state, PCWre, IRWre, RegWre, mRD, mWR, RegDst, DBDataSrc, ALUOp, PCSrc};
            want = {tbl[i].st, tbl[i].pcwre, tbl[i].irwre, tbl[i].regwre, tbl[i].mrd,
                    tbl[i].mwr, tbl[i].regdst, tbl[i].dbd, tbl[i].aluop, tbl[i].pcsrc};
            checks++;
            if (got !== want) begin
                errs++;
                $display("FAIL vec%0d op=%b: got %h want %h", i, tbl[i].op, got, want);
            end
        end

        // ---------------- halt park and reset release ----------------
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); ph = 0;
        step(0, HALT, 0, "halt_if");
        step(0, HALT, 0, "halt_id");
        for (int k = 0; k < 12; k++) begin
            step(0, HALT, 1'($urandom_range(0, 1)), "halt_hold");
            checks++;
            if ({PCWre, IRWre, InsMemRW, RegWre, mRD, mWR} !== 6'b0 || state !== 3'd7) begin
                errs++;
                $display("FAIL halt_enables: got st=%0d en=%b want st=7 en=000000",
                         state, {PCWre, IRWre, InsMemRW, RegWre, mRD, mWR});
            end
        end
        step(1, HALT, 0, "halt_rst");
        step(0, ADD, 0, "after_halt_if");

        // ---------------- randomized instruction stream ----------------
        cur = ADD;
        for (int n = 0; n < 3000; n++) begin
            if (ph == 0) begin
                case ($urandom_range(0, 15))
                    0: cur = ADD;   1: cur = SUB;  2: cur = ADDI; 3: cur = OR_;
                    4: cur = AND_;  5: cur = ORI;  6: cur = SLL;  7: cur = SLT;
                    8: cur = SW;    9: cur = LW;   10: cur = BEQ; 11: cur = J;
                    12: cur = HALT; default: cur = 6'($urandom);
                endcase
            end
            step(($urandom_range(0, 39) == 0), cur, 1'($urandom_range(0, 1)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
